// File: rtl/mm_job_scheduler.sv
// Round-robin front end that shares one 2x2 8-bit matrix-multiply engine among
// NUM_REQ requesters, one outstanding job at a time, with an engine-hang timeout.
module mm_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_accum,
    input  logic [64*NUM_REQ-1:0]   req_opnd,
    output logic [63:0]             mm_opnd,
    output logic                    mm_start,
    output logic                    mm_accumulate,
    input  logic                    mm_done,
    input  logic [63:0]             mm_result,
    input  logic                    mm_overflow,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [63:0]             rsp_data,
    output logic                    rsp_overflow,
    output logic                    rsp_acc_dropped,
    output logic                    rsp_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [63:0]       hold_q, hold_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              eff_acc_q, eff_acc_d;
    logic              acc_drop_q, acc_drop_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic              last_vld_q, last_vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              to_q, to_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [63:0]       grant_opnd;
    logic              grant_acc;
    logic              acc_hit;

    // Winner search: requesters at or above the pointer first, then wrap to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_opnd  = '0;
        grant_acc   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                grant_opnd = req_opnd[i*64 +: 64];
                grant_acc  = req_accum[i];
            end
        end
    end

    // Accumulating is only safe when the engine still holds this requester's result.
    assign acc_hit = grant_acc & last_vld_q & (last_id_q == grant_id);

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only, so
        // every register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            hold_q     <= '0;
            id_q       <= '0;
            eff_acc_q  <= 1'b0;
            acc_drop_q <= 1'b0;
            last_id_q  <= '0;
            last_vld_q <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            id_q       <= id_d;
            eff_acc_q  <= eff_acc_d;
            acc_drop_q <= acc_drop_d;
            last_id_q  <= last_id_d;
            last_vld_q <= last_vld_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            to_q       <= to_d;
        end
    end

    always_comb begin
        // NOTE: every _d defaults to its register first, so no path infers a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        id_d       = id_q;
        eff_acc_d  = eff_acc_q;
        acc_drop_d = acc_drop_q;
        last_id_d  = last_id_q;
        last_vld_d = last_vld_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        to_d       = to_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    hold_d     = grant_opnd;
                    id_d       = grant_id;
                    eff_acc_d  = acc_hit;
                    acc_drop_d = grant_acc & ~acc_hit;
                    ptr_d      = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mm_done) begin
                    data_d     = mm_result;
                    ovf_d      = mm_overflow;
                    to_d       = 1'b0;
                    last_id_d  = id_q;
                    last_vld_d = 1'b1;
                    state_d    = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Engine accumulator contents are unknown after a hang.
                    data_d     = '0;
                    ovf_d      = 1'b0;
                    to_d       = 1'b1;
                    last_vld_d = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state_q == S_IDLE) && !rst && grant_found && (grant_id == ID_W'(i));
        end
        mm_start        = (state_q == S_ISSUE);
        mm_opnd         = (state_q == S_ISSUE || state_q == S_WAIT) ? hold_q : '0;
        mm_accumulate   = (state_q == S_ISSUE || state_q == S_WAIT) && eff_acc_q;
        rsp_valid       = (state_q == S_RESP);
        rsp_id          = rsp_valid ? id_q : '0;
        rsp_data        = rsp_valid ? data_q : '0;
        rsp_overflow    = rsp_valid && ovf_q;
        rsp_acc_dropped = rsp_valid && acc_drop_q;
        rsp_timeout     = rsp_valid && to_q;
    end

endmodule
